manual_bp_seq: RTL

- Next-generation manual dead-pixel list sequencer. Holds a host-written, raster-sorted list of bad-pixel coordinates in two ping-pong LUT banks.
- Generates raster coordinates from the pixel stream and walks the list in lock-step with it. Flags each pixel whose coordinate matches the current list entry.
- Sits between the video input and the correction kernel. Host reloads the list without tearing; the new bank is committed at frame boundaries.

---
 rtl/manual_bp_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/manual_bp_seq.sv
// rtl/manual_bp_seq.sv - manual dead-pixel list sequencer with ping-pong LUT banks
module manual_bp_seq #(
   parameter int WIDTH_BITS    = 10,
   parameter int HEIGHT_BITS   = 10,
   parameter int BAD_POINT_NUM = 128,
   parameter int BAD_POINT_BIT = $clog2(BAD_POINT_NUM)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH_BITS-1:0]    img_width,
   input  logic [HEIGHT_BITS-1:0]   img_height,
   input  logic                     s_valid,
   input  logic                     s_sof,
   output logic                     m_valid,
   output logic                     m_sof,
   output logic                     m_hit,
   output logic [WIDTH_BITS-1:0]    m_x,
   output logic [HEIGHT_BITS-1:0]   m_y,
   output logic                     active_bank,
   output logic                     err_order,
   output logic                     err_miss,
   input  logic                     err_clr,
   input  logic                     S_AXI_ACLK,
   input  logic                     wen_lut,
   input  logic [BAD_POINT_BIT-1:0] waddr_lut,
   input  logic [31:0]              wdata_lut,
   input  logic                     commit,
   input  logic [BAD_POINT_BIT:0]   commit_num
);
   localparam int EW = WIDTH_BITS + HEIGHT_BITS;
   localparam int AW = BAD_POINT_BIT + 1;

   typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_ARMED, S_RUN} state_t;

   state_t                   state, state_nx;
   logic [EW-1:0]            mem [0:2*BAD_POINT_NUM-1];
   logic [EW-1:0]            rdata;
   logic [BAD_POINT_BIT-1:0] ridx;
   logic                     commit_tgl_w;
   logic [AW-1:0]            commit_cnt_w;
   logic                     tgl_s1, tgl_s2, tgl_s3, pend;
   logic [AW-1:0]            cnt, ptr, fptr;
   logic [EW-1:0]            cur, nxt;
   logic                     nxt_pend;
   logic [1:0]               pf_cnt;
   logic [WIDTH_BITS-1:0]    x, cx, cur_x;
   logic [HEIGHT_BITS-1:0]   y, cy, cur_y;
   logic                     pix_sof, x_last, y_last, eof, in_frame, cand;
   logic                     hit_now, behind, advance, miss, frame_end, swap;
   logic                     unused_bits;

   assign unused_bits = ^{wdata_lut[31:16+WIDTH_BITS], wdata_lut[15:HEIGHT_BITS], fptr[BAD_POINT_BIT]};
   assign cur_x = cur[HEIGHT_BITS +: WIDTH_BITS];
   assign cur_y = cur[0 +: HEIGHT_BITS];

   // Host side: entries always land in the bank not being sequenced.
   always_ff @(posedge S_AXI_ACLK) begin
      if (wen_lut)
         mem[{~active_bank, waddr_lut}] <= {wdata_lut[16 +: WIDTH_BITS], wdata_lut[0 +: HEIGHT_BITS]};
   end

   always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         commit_tgl_w <= 1'b0;
         commit_cnt_w <= '0;
      end else if (commit) begin
         commit_tgl_w <= ~commit_tgl_w;
         commit_cnt_w <= commit_num;
      end
   end

   always_ff @(posedge clk) begin
      rdata <= mem[{active_bank, ridx}];
   end

   always_comb begin
      pix_sof   = s_valid & s_sof;
      cx        = pix_sof ? '0 : x;
      cy        = pix_sof ? '0 : y;
      x_last    = (cx == img_width - 1'b1);
      y_last    = (cy == img_height - 1'b1);
      eof       = s_valid & x_last & y_last;
      in_frame  = s_valid & (((state == S_RUN) & ~s_sof) | ((state == S_ARMED) & s_sof));
      cand      = in_frame & (ptr < cnt) & (cur_x < img_width) & (cur_y < img_height);
      hit_now   = cand & (cur_x == cx) & (cur_y == cy);
      behind    = cand & ((cur_y < cy) | ((cur_y == cy) & (cur_x < cx)));
      advance   = hit_now | behind;
      miss      = pix_sof & (state != S_ARMED);
      frame_end = in_frame & eof;
      swap      = pend & ((state == S_IDLE) | frame_end);
      ridx      = (state == S_PREFETCH) ? BAD_POINT_BIT'(pf_cnt != 2'd0) : fptr[BAD_POINT_BIT-1:0];
      state_nx  = state;
      case (state)
         S_IDLE:     if (swap | eof | miss) state_nx = S_PREFETCH;
         S_PREFETCH: if (pf_cnt == 2'd2) state_nx = S_ARMED;
         S_ARMED:    if (frame_end) state_nx = S_PREFETCH;
                     else if (pix_sof) state_nx = S_RUN;
         S_RUN:      if (frame_end | miss) state_nx = S_PREFETCH;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {tgl_s1, tgl_s2, tgl_s3, pend} <= '0;
         active_bank <= 1'b0;
         cnt         <= '0;
      end else begin
         tgl_s1 <= commit_tgl_w;
         tgl_s2 <= tgl_s1;
         tgl_s3 <= tgl_s2;
         pend   <= (tgl_s2 ^ tgl_s3) | (pend & ~swap);
         if (swap) begin
            active_bank <= ~active_bank;
            cnt         <= commit_cnt_w;
         end
      end
   end

   // cur/nxt lookahead; while nxt_pend, rdata holds the entry after cur
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         fptr     <= '0;
         cur      <= '0;
         nxt      <= '0;
         nxt_pend <= 1'b0;
         pf_cnt   <= '0;
      end else begin
         pf_cnt <= ((state == S_PREFETCH) && (pf_cnt != 2'd2)) ? pf_cnt + 1'b1 : 2'd0;
         if (state == S_PREFETCH) begin
            ptr      <= '0;
            fptr     <= AW'(2);
            nxt_pend <= 1'b0;
            if (pf_cnt == 2'd1) cur <= rdata;
            if (pf_cnt == 2'd2) nxt <= rdata;
         end else if (advance) begin
            ptr      <= ptr + 1'b1;
            fptr     <= fptr + 1'b1;
            cur      <= nxt_pend ? rdata : nxt;
            nxt_pend <= 1'b1;
         end else if (nxt_pend) begin
            nxt      <= rdata;
            nxt_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         y         <= '0;
         m_valid   <= 1'b0;
         m_sof     <= 1'b0;
         m_hit     <= 1'b0;
         m_x       <= '0;
         m_y       <= '0;
         err_order <= 1'b0;
         err_miss  <= 1'b0;
      end else begin
         m_valid <= s_valid;
         m_sof   <= pix_sof;
         m_hit   <= hit_now;
         if (s_valid) begin
            m_x <= cx;
            m_y <= cy;
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : cy + 1'b1;
            end else begin
               x <= cx + 1'b1;
               y <= cy;
            end
         end
         if (behind)       err_order <= 1'b1;
         else if (err_clr) err_order <= 1'b0;
         if (miss)         err_miss  <= 1'b1;
         else if (err_clr) err_miss  <= 1'b0;
      end
   end
endmodule
